// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with EX/MEM register and a multi-cycle
// mult/div unit driving the HI/LO registers.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   RegWrite..RegDst  control bits from ID/EX
//   ALUControl        operation select (11xx = mult/div family)
//   RD1, RD2, SignImm, PCplus4, Rt, Rd   ID/EX datapath
//   HiLoRead          01 = MFHI, 10 = MFLO, otherwise ALU result
//   Flush             squash EX/MEM and abort any mult/div
//   Stall             combinational hold request to upstream stages
//   M_*               EX/MEM register outputs
//   HI, LO            current HI/LO register contents
module ex_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic        ALUSrc,
    input  logic        ALUSrc_shamt,
    input  logic        RegDst,
    input  logic [3:0]  ALUControl,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic [31:0] SignImm,
    input  logic [31:0] PCplus4,
    input  logic [4:0]  Rt,
    input  logic [4:0]  Rd,
    input  logic [1:0]  HiLoRead,
    input  logic        Flush,
    output logic        Stall,
    output logic        M_RegWrite,
    output logic        M_MemtoReg,
    output logic        M_MemWrite,
    output logic        M_Branch,
    output logic        M_Zero,
    output logic [31:0] M_ALUOut,
    output logic [31:0] M_WriteData,
    output logic [31:0] M_PCBranch,
    output logic [4:0]  M_WriteReg,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [1:0]  mop_q, mop_d;   // [1]: divide, [0]: unsigned
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        m_regwrite_q, m_regwrite_d;
    logic        m_memtoreg_q, m_memtoreg_d;
    logic        m_memwrite_q, m_memwrite_d;
    logic        m_branch_q, m_branch_d;
    logic        m_zero_q, m_zero_d;
    logic [31:0] m_aluout_q, m_aluout_d;
    logic [31:0] m_writedata_q, m_writedata_d;
    logic [31:0] m_pcbranch_q, m_pcbranch_d;
    logic [4:0]  m_writereg_q, m_writereg_d;

    logic [31:0] src_a, src_b, alu_res, result;
    logic [4:0]  shamt;
    logic        md_op;
    logic [63:0] prod;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, mag_b_safe, q_mag, r_mag;
    logic [31:0] md_hi, md_lo;

    // ---------------- ALU ----------------
    always_comb begin
        src_a   = RD1;
        src_b   = ALUSrc ? SignImm : RD2;
        shamt   = ALUSrc_shamt ? SignImm[10:6] : RD1[4:0];
        md_op   = (ALUControl[3:2] == 2'b11);
        alu_res = '0;
        case (ALUControl)
            4'b0000: alu_res = src_a & src_b;
            4'b0001: alu_res = src_a | src_b;
            4'b0010: alu_res = src_a + src_b;
            4'b0011: alu_res = src_a ^ src_b;
            4'b0100: alu_res = ~(src_a | src_b);
            4'b0110: alu_res = src_a - src_b;
            4'b0111: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            4'b1011: alu_res = {31'd0, src_a < src_b};
            4'b1000: alu_res = src_b << shamt;
            4'b1001: alu_res = src_b >> shamt;
            4'b1010: alu_res = $unsigned($signed(src_b) >>> shamt);
            default: alu_res = '0;
        endcase
        case (HiLoRead)
            2'b01:   result = hi_q;
            2'b10:   result = lo_q;
            default: result = alu_res;
        endcase
    end

    // ---------------- mult/div arithmetic on latched operands ----------------
    // Signed divide is done on magnitudes so that 0x80000000 / -1 falls out
    // as 0x80000000 rem 0 without relying on tool overflow behaviour.
    always_comb begin
        if (mop_q[0])
            prod = {32'd0, opa_q} * {32'd0, opb_q};
        else
            prod = {{32{opa_q[31]}}, opa_q} * {{32{opb_q[31]}}, opb_q};
        neg_a      = ~mop_q[0] & opa_q[31];
        neg_b      = ~mop_q[0] & opb_q[31];
        mag_a      = neg_a ? (~opa_q + 32'd1) : opa_q;
        mag_b      = neg_b ? (~opb_q + 32'd1) : opb_q;
        mag_b_safe = (mag_b == '0) ? 32'd1 : mag_b;
        q_mag      = mag_a / mag_b_safe;
        r_mag      = mag_a % mag_b_safe;
        if (!mop_q[1]) begin
            md_hi = prod[63:32];
            md_lo = prod[31:0];
        end else if (opb_q == '0) begin
            md_hi = opa_q;
            md_lo = '1;
        end else begin
            md_lo = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
            md_hi = neg_a ? (~r_mag + 32'd1) : r_mag;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            mop_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            mop_q   <= mop_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        mop_d   = mop_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (Flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_op) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        opa_d   = src_a;
                        opb_d   = src_b;
                        mop_d   = ALUControl[1:0];
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                        hi_d    = md_hi;
                        lo_d    = md_lo;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Stall = ~RST & ~Flush &
                (((state_q == IDLE) & md_op) | (state_q == BUSY));
    end

    // ---------------- EX/MEM register ----------------
    always_comb begin
        logic bubble;
        bubble        = Flush | Stall;
        m_regwrite_d  = ~bubble & RegWrite & (state_q != DONE);
        m_memwrite_d  = ~bubble & MemWrite & (state_q != DONE);
        m_memtoreg_d  = ~bubble & MemtoReg;
        m_branch_d    = ~bubble & Branch;
        m_aluout_d    = result;
        m_zero_d      = (result == '0);
        m_writedata_d = RD2;
        m_writereg_d  = RegDst ? Rd : Rt;
        m_pcbranch_d  = PCplus4 + {SignImm[29:0], 2'b00};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_regwrite_q  <= 1'b0;
            m_memtoreg_q  <= 1'b0;
            m_memwrite_q  <= 1'b0;
            m_branch_q    <= 1'b0;
            m_zero_q      <= 1'b0;
            m_aluout_q    <= '0;
            m_writedata_q <= '0;
            m_pcbranch_q  <= '0;
            m_writereg_q  <= '0;
        end else begin
            m_regwrite_q  <= m_regwrite_d;
            m_memtoreg_q  <= m_memtoreg_d;
            m_memwrite_q  <= m_memwrite_d;
            m_branch_q    <= m_branch_d;
            m_zero_q      <= m_zero_d;
            m_aluout_q    <= m_aluout_d;
            m_writedata_q <= m_writedata_d;
            m_pcbranch_q  <= m_pcbranch_d;
            m_writereg_q  <= m_writereg_d;
        end
    end

    assign M_RegWrite  = m_regwrite_q;
    assign M_MemtoReg  = m_memtoreg_q;
    assign M_MemWrite  = m_memwrite_q;
    assign M_Branch    = m_branch_q;
    assign M_Zero      = m_zero_q;
    assign M_ALUOut    = m_aluout_q;
    assign M_WriteData = m_writedata_q;
    assign M_PCBranch  = m_pcbranch_q;
    assign M_WriteReg  = m_writereg_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized scoreboard bench for ex_stage. The driver issues
// instructions cycle by cycle, computing the expected EX/MEM contents and
// HI/LO from a behavioural model; a monitor pops and compares after each edge.
module tb_ex_stage;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst;
    logic [3:0]  ALUControl;
    logic [31:0] RD1, RD2, SignImm, PCplus4;
    logic [4:0]  Rt, Rd;
    logic [1:0]  HiLoRead;
    logic        Flush;
    logic        Stall;
    logic        M_RegWrite, M_MemtoReg, M_MemWrite, M_Branch, M_Zero;
    logic [31:0] M_ALUOut, M_WriteData, M_PCBranch;
    logic [4:0]  M_WriteReg;
    logic [31:0] HI, LO;

    ex_stage dut (
        .CLK(CLK), .RST(RST),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .Branch(Branch), .ALUSrc(ALUSrc), .ALUSrc_shamt(ALUSrc_shamt),
        .RegDst(RegDst), .ALUControl(ALUControl),
        .RD1(RD1), .RD2(RD2), .SignImm(SignImm), .PCplus4(PCplus4),
        .Rt(Rt), .Rd(Rd), .HiLoRead(HiLoRead), .Flush(Flush), .Stall(Stall),
        .M_RegWrite(M_RegWrite), .M_MemtoReg(M_MemtoReg), .M_MemWrite(M_MemWrite),
        .M_Branch(M_Branch), .M_Zero(M_Zero), .M_ALUOut(M_ALUOut),
        .M_WriteData(M_WriteData), .M_PCBranch(M_PCBranch),
        .M_WriteReg(M_WriteReg), .HI(HI), .LO(LO)
    );

    typedef struct {
        logic [3:0]  op;
        logic        rw, mtr, mw, br, alusrc, shs, regdst;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rt, rd;
        logic [1:0]  hlr;
    } inst_t;

    typedef struct {
        logic        stall;
        logic        care;      // WriteData / WriteReg / PCBranch defined
        logic        care_alu;  // ALUOut / Zero defined
        logic        rw, mtr, mw, br, z;
        logic [31:0] alu, wd, pcb;
        logic [4:0]  wr;
        logic [31:0] hi, lo;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(inst_t i);
        logic [31:0] a, b, r;
        int          sh;
        a  = i.rd1;
        b  = i.alusrc ? i.imm : i.rd2;
        sh = i.shs ? int'(i.imm[10:6]) : int'(i.rd1[4:0]);
        case (i.op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd3:    r = a ^ b;
            4'd4:    r = ~(a | b);
            4'd6:    r = a - b;
            4'd7:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd11:   r = (a < b) ? 32'd1 : 32'd0;
            4'd8:    r = b << sh;
            4'd9:    r = b >> sh;
            4'd10:   r = $unsigned($signed(b) >>> sh);
            default: r = 32'd0;
        endcase
        if (i.hlr == 2'b01) r = hi_m;
        else if (i.hlr == 2'b10) r = lo_m;
        return r;
    endfunction

    task automatic ref_muldiv(inst_t i);
        logic [31:0] a, b;
        logic [63:0] p;
        longint      sa, sb2;
        a   = i.rd1;
        b   = i.rd2;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (i.op[1:0])
            2'd0: begin p = 64'(sa * sb2); hi_m = p[63:32]; lo_m = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
            2'd2: begin
                if (b == 0) begin lo_m = 32'hFFFFFFFF; hi_m = a; end
                else begin lo_m = 32'(sa / sb2); hi_m = 32'(sa % sb2); end
            end
            default: begin
                if (b == 0) begin lo_m = 32'hFFFFFFFF; hi_m = a; end
                else begin lo_m = a / b; hi_m = a % b; end
            end
        endcase
    endtask

    function automatic exp_t bubble_e(logic st);
        exp_t e;
        e = '{stall: st, care: 1'b0, care_alu: 1'b0, rw: 1'b0, mtr: 1'b0, mw: 1'b0,
              br: 1'b0, z: 1'b0, alu: '0, wd: '0, pcb: '0, wr: '0, hi: hi_m, lo: lo_m};
        return e;
    endfunction

    function automatic exp_t load_e(inst_t i);
        exp_t e;
        e.stall    = 1'b0;
        e.care     = 1'b1;
        e.care_alu = 1'b1;
        e.rw       = i.rw;
        e.mtr      = i.mtr;
        e.mw       = i.mw;
        e.br       = i.br;
        e.alu      = ref_result(i);
        e.z        = (e.alu == 0);
        e.wd       = i.rd2;
        e.wr       = i.regdst ? i.rd : i.rt;
        e.pcb      = i.pc4 + (i.imm << 2);
        e.hi       = hi_m;
        e.lo       = lo_m;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(inst_t i, logic fl);
        RegWrite = i.rw; MemtoReg = i.mtr; MemWrite = i.mw; Branch = i.br;
        ALUSrc = i.alusrc; ALUSrc_shamt = i.shs; RegDst = i.regdst;
        ALUControl = i.op; RD1 = i.rd1; RD2 = i.rd2; SignImm = i.imm;
        PCplus4 = i.pc4; Rt = i.rt; Rd = i.rd; HiLoRead = i.hlr; Flush = fl;
    endtask

    task automatic cycle(inst_t i, logic fl, exp_t e);
        @(negedge CLK);
        drive(i, fl);
        #1;
        checks++;
        if (Stall !== e.stall) begin
            errors++;
            $display("FAIL stall: op=%h flush=%b got=%b exp=%b", i.op, fl, Stall, e.stall);
        end
        sb.push_back(e);
    endtask

    // flush_at: -1 none; ALU ops flush only at 0; mult/div cycle index 0..33
    task automatic issue(inst_t i, int flush_at);
        exp_t e;
        if (i.op[3:2] != 2'b11) begin
            if (flush_at == 0) cycle(i, 1'b1, bubble_e(1'b0));
            else cycle(i, 1'b0, load_e(i));
        end else begin
            for (int c = 0; c < 34; c++) begin
                if (c == flush_at) begin
                    cycle(i, 1'b1, bubble_e(1'b0));
                    return;
                end
                if (c == 32) ref_muldiv(i);
                if (c < 33) begin
                    cycle(i, 1'b0, bubble_e(1'b1));
                end else begin
                    e      = load_e(i);
                    e.rw   = 1'b0;
                    e.mw   = 1'b0;
                    e.care_alu = 1'b0;
                    cycle(i, 1'b0, e);
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always begin
        exp_t e;
        logic ok;
        @(posedge CLK);
        #1;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            ok = (M_RegWrite === e.rw) && (M_MemtoReg === e.mtr) &&
                 (M_MemWrite === e.mw) && (M_Branch === e.br) &&
                 (HI === e.hi) && (LO === e.lo);
            if (e.care)
                ok = ok && (M_WriteData === e.wd) && (M_WriteReg === e.wr) &&
                     (M_PCBranch === e.pcb);
            if (e.care_alu)
                ok = ok && (M_ALUOut === e.alu) && (M_Zero === e.z);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL exmem: got ctl=%b%b%b%b z=%b alu=%h wd=%h wr=%0d pcb=%h hi=%h lo=%h exp ctl=%b%b%b%b z=%b alu=%h wd=%h wr=%0d pcb=%h hi=%h lo=%h care=%b%b",
                         M_RegWrite, M_MemtoReg, M_MemWrite, M_Branch, M_Zero, M_ALUOut,
                         M_WriteData, M_WriteReg, M_PCBranch, HI, LO,
                         e.rw, e.mtr, e.mw, e.br, e.z, e.alu, e.wd, e.wr, e.pcb, e.hi, e.lo,
                         e.care, e.care_alu);
            end
        end
    end

    task automatic check32(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(string name);
        logic [170:0] v;
        v = {Stall, M_RegWrite, M_MemtoReg, M_MemWrite, M_Branch, M_Zero, M_ALUOut,
             M_WriteData, M_PCBranch, M_WriteReg, HI, LO};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: outputs not cleared got=%h exp=0", name, v);
        end
    endtask

    function automatic inst_t nop_inst();
        inst_t i;
        i = '{op: 4'd0, rw: 1'b0, mtr: 1'b0, mw: 1'b0, br: 1'b0, alusrc: 1'b0,
              shs: 1'b0, regdst: 1'b0, rd1: '0, rd2: '0, imm: '0, pc4: '0,
              rt: '0, rd: '0, hlr: 2'b00};
        return i;
    endfunction

    function automatic inst_t rand_inst();
        inst_t i;
        i.rw = 1'($urandom); i.mtr = 1'($urandom); i.mw = 1'($urandom);
        i.br = 1'($urandom); i.alusrc = 1'($urandom); i.shs = 1'($urandom);
        i.regdst = 1'($urandom);
        i.rd1 = $urandom; i.imm = $urandom; i.pc4 = $urandom;
        i.rd2 = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        if ($urandom_range(0, 5) == 0) i.rd1 = 32'h80000000;
        i.rt = 5'($urandom); i.rd = 5'($urandom);
        i.hlr = 2'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            i.op = {2'b11, 2'($urandom)};
            i.alusrc = 1'b0;
            i.hlr = 2'b00;
            if ($urandom_range(0, 5) == 0) i.rd2 = 32'hFFFFFFFF;
        end else begin
            i.op = 4'($urandom_range(0, 11));
        end
        return i;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        inst_t i;
        int    fa;
        RST = 1'b1;
        drive(nop_inst(), 1'b0);
        #1;
        check_reset_outputs("reset_state");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // ADD wrap to zero
        i = nop_inst(); i.op = 4'd2; i.rw = 1'b1; i.rd1 = 32'hFFFFFFFF; i.rd2 = 32'd1;
        i.rt = 5'd3; i.rd = 5'd9; i.regdst = 1'b1; i.imm = 32'hFFFFFFFF; i.pc4 = 32'h10;
        issue(i, -1);
        // SRA by immediate shamt
        i = nop_inst(); i.op = 4'd10; i.rw = 1'b1; i.shs = 1'b1; i.imm = 32'h100;
        i.rd2 = 32'h80000000; i.rd1 = 32'h1F;
        issue(i, -1);
        // MULT -3 * 7, then MFLO and MFHI
        i = nop_inst(); i.op = 4'd12; i.rw = 1'b1; i.rd1 = -32'sd3; i.rd2 = 32'd7;
        issue(i, -1);
        check32("mult_hi", HI, 32'hFFFFFFFF);
        check32("mult_lo", LO, 32'hFFFFFFEB);
        i = nop_inst(); i.rw = 1'b1; i.hlr = 2'b10;
        issue(i, -1);
        i.hlr = 2'b01;
        issue(i, -1);
        // DIV -7 / 2
        i = nop_inst(); i.op = 4'd14; i.rd1 = -32'sd7; i.rd2 = 32'd2;
        issue(i, -1);
        check32("div_lo", LO, 32'hFFFFFFFD);
        check32("div_hi", HI, 32'hFFFFFFFF);
        // DIVU by zero
        i = nop_inst(); i.op = 4'd15; i.rd1 = 32'h12345678; i.rd2 = 32'd0;
        issue(i, -1);
        check32("divu0_lo", LO, 32'hFFFFFFFF);
        check32("divu0_hi", HI, 32'h12345678);
        // DIV overflow case
        i = nop_inst(); i.op = 4'd14; i.rd1 = 32'h80000000; i.rd2 = 32'hFFFFFFFF;
        issue(i, -1);
        check32("divovf_lo", LO, 32'h80000000);
        check32("divovf_hi", HI, 32'h00000000);
        // Flush while BUSY at cnt=10: HI/LO keep overflow-case values
        i = nop_inst(); i.op = 4'd13; i.rd1 = 32'hDEADBEEF; i.rd2 = 32'h1234;
        issue(i, 11);
        check32("flush_hi", HI, 32'h00000000);
        check32("flush_lo", LO, 32'h80000000);
        i = nop_inst(); i.op = 4'd1; i.rw = 1'b1; i.rd1 = 32'h0F0F0000; i.rd2 = 32'h000000F0;
        issue(i, -1);

        // Reset mid-BUSY, asserted between edges
        i = nop_inst(); i.op = 4'd12; i.rd1 = 32'd5; i.rd2 = 32'd6;
        for (int c = 0; c < 6; c++) cycle(i, 1'b0, bubble_e(1'b1));
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("reset_mid_busy");
        hi_m = '0;
        lo_m = '0;
        @(negedge CLK);
        drive(nop_inst(), 1'b0);
        RST = 1'b0;
        i = nop_inst(); i.op = 4'd6; i.rw = 1'b1; i.rd1 = 32'd0; i.rd2 = 32'd1; i.hlr = 2'b01;
        issue(i, -1);

        // Randomized traffic with occasional flushes
        for (int n = 0; n < 150; n++) begin
            i  = rand_inst();
            fa = -1;
            if (i.op[3:2] == 2'b11) begin
                if ($urandom_range(0, 3) == 0) fa = $urandom_range(0, 33);
            end else if ($urandom_range(0, 9) == 0) begin
                fa = 0;
            end
            issue(i, fa);
        end

        @(negedge CLK);
        drive(nop_inst(), 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d pending exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
